inv_mix_columns_seq: RTL
========================

// Module: inv_mix_columns_seq
// PURPOSE
//   Sequential AES InvMixColumns engine for the decryption datapath. It inverts the
//   forward MixColumns byte unit: it accepts a full 128-bit state over a valid/ready
//   handshake, computes LANES output bytes per cycle in GF(2^8), and presents the
//   128-bit result over a second valid/ready handshake. It sits between InvShiftRows/
//   InvSubBytes and AddRoundKey in the inverse-cipher round loop.
// PARAMETERS
//   LANES  1  output bytes computed per cycle; legal values 1, 2 and 4 (elaboration error otherwise)
// PORTS
//   clk        in   1    single clock; all logic is on its rising edge
//   rst        in   1    synchronous reset, active-high
//   in_valid   in   1    state_in is valid
//   in_ready   out  1    block can capture state_in
//   state_in   in   128  input state; byte k = state_in[127-8k -: 8], k = 4*col + row
//   out_valid  out  1    state_out holds a completed result
//   out_ready  in   1    consumer accepts state_out
//   state_out  out  128  result, same byte ordering as state_in
//   busy       out  1    high in CALC or DONE
// BEHAVIOUR
//   - Reset (rst=1 at a clock edge): FSM goes to IDLE; out_valid=0; state_out=0;
//     byte index=0; internal input register cleared. rst overrides every other input.
//   - FSM states: IDLE -> CALC -> DONE -> IDLE.
//     IDLE: in_ready=1, busy=0. When in_valid is high, capture state_in into src_q,
//       set idx=0 and go to CALC.
//     CALC: in_ready=0. Each cycle, write bytes idx..idx+LANES-1 of res_q, with
//       idx += LANES. After writing byte 15, go to DONE. idx wraps to 0.
//     DONE: out_valid=1 and state_out=res_q, both held stable until out_ready=1.
//       On out_ready, go to IDLE the next cycle. in_ready stays 0 in DONE, including
//       the cycle out_ready is seen; there is no overlap of consecutive blocks.
//   - Latency: handshake at edge T. CALC occupies N=16/LANES cycles. out_valid is high
//     in the cycle after edge T+N (17 cycles for LANES=1, 5 cycles for LANES=4).
//     Throughput is one block per N+2 cycles with out_ready tied high.
//   - Arithmetic, per output byte (row r, col c):
//       s'[r,c] = XOR over j of mul(K[r][j], src[j,c])
//     The coefficient matrix K is the circulant with first row 0E 0B 0D 09:
//       row0 0E 0B 0D 09 | row1 09 0E 0B 0D | row2 0D 09 0E 0B | row3 0B 0D 09 0E
//     xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00)
//       x2=xtime(b), x4=xtime(x2), x8=xtime(x4)
//       mul09=x8^b, mul0B=x8^x2^b, mul0D=x8^x4^b, mul0E=x8^x4^x2
//     All values are 8 bits wide; no carries exist.
//   - Results are written only to res_q; src_q is never modified during CALC.
//   - state_out is driven from res_q only. While out_valid=0 its value is don't-care
//     for consumers but is deterministic (0 after reset, otherwise the last result).
//   - rst asserted in CALC or DONE aborts the block: no out_valid pulse, FSM returns to IDLE.
//   - in_valid asserted while not in IDLE is ignored (in_ready=0).
// STRUCTURE
//   - Shared package aes_pkg:
//       typedef logic [7:0] aes_byte_t; typedef logic [127:0] aes_state_t;
//       function xtime(); constant INV_MC_COEF[4][4] holding the matrix above.
//   - Sub-module inv_mix_byte: combinational. Inputs row[1:0] and col bytes b0..b3;
//     output one byte. Instantiated LANES times.
//   - Top level holds the FSM, idx counter, src_q/res_q registers and output muxing.
// TESTING
//   1. Column 8e 4d a1 bc (other columns 0) -> result column 0 = db 13 53 45; LANES=1
//      gives out_valid 17 cycles after the handshake.
//   2. Column 9f dc 58 9d -> f2 0a 22 5c; column d5 d5 d7 d6 -> d4 d4 d4 d5.
//   3. Uniform columns 01 01 01 01 and c6 c6 c6 c6 -> unchanged (row XOR of K = 01);
//      run for LANES=1, 2 and 4 and compare against the same golden state.
//   4. Hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out stay stable,
//      in_ready=0; release -> in_ready=1 on the next cycle.
//   5. Assert rst in the 5th CALC cycle -> no out_valid, in_ready=1 the cycle after
//      rst is released, and the next block produces a correct result.
//   6. 200 random states through a forward-MixColumns model and this block ->
//      each output equals the original state; in_valid pulses while busy are ignored.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher datapath.
//   aes_byte_t / aes_state_t : byte and 128-bit state types
//   INV_MC_COEF              : InvMixColumns circulant coefficient matrix K[row][j]
//   xtime                    : multiply by x (02) in GF(2^8), AES polynomial 0x11B
//   inv_coef_mul             : multiply a byte by one of 09/0B/0D/0E
//   state_byte               : byte k of a state, k = 4*col + row, byte 0 in the MSBs
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } imc_state_e;

  localparam aes_byte_t INV_MC_COEF [4][4] = '{
    '{8'h0e, 8'h0b, 8'h0d, 8'h09},
    '{8'h09, 8'h0e, 8'h0b, 8'h0d},
    '{8'h0d, 8'h09, 8'h0e, 8'h0b},
    '{8'h0b, 8'h0d, 8'h09, 8'h0e}
  };

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the four InvMixColumns coefficients are supported; anything else yields 0.
  function automatic aes_byte_t inv_coef_mul(input aes_byte_t coef, input aes_byte_t b);
    aes_byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (coef)
      8'h09:   return x8 ^ b;
      8'h0b:   return x8 ^ x2 ^ b;
      8'h0d:   return x8 ^ x4 ^ b;
      8'h0e:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic aes_byte_t state_byte(input aes_state_t s, input logic [3:0] k);
    return s[127 - 8*k -: 8];
  endfunction

endpackage

// File: rtl/inv_mix_byte.sv
// Combinational InvMixColumns for a single output byte.
//   row    : output row (0..3) selecting the coefficient row of K
//   b0..b3 : the four bytes of the source column, row 0 first
//   result : XOR over j of K[row][j] * bj in GF(2^8)
module inv_mix_byte
  import aes_pkg::*;
(
  input  logic [1:0] row,
  input  aes_byte_t  b0,
  input  aes_byte_t  b1,
  input  aes_byte_t  b2,
  input  aes_byte_t  b3,
  output aes_byte_t  result
);

  always_comb begin
    result = inv_coef_mul(INV_MC_COEF[row][0], b0)
           ^ inv_coef_mul(INV_MC_COEF[row][1], b1)
           ^ inv_coef_mul(INV_MC_COEF[row][2], b2)
           ^ inv_coef_mul(INV_MC_COEF[row][3], b3);
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns engine: captures a 128-bit state, produces LANES
// result bytes per cycle, then holds the result until the consumer accepts it.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake for state_in (accepted only in IDLE)
//   state_in             : input state, byte k = state_in[127-8k -: 8], k = 4*col + row
//   out_valid / out_ready: output handshake for state_out (held stable in DONE)
//   state_out            : result state, same byte order, driven from res_q
//   busy                 : high while a block is in CALC or DONE
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t state_in,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t state_out,
  output logic       busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("inv_mix_columns_seq: LANES must be 1, 2 or 4");
  end

  imc_state_e state_q, state_d;
  logic [3:0] idx_q;
  aes_state_t src_q, res_q;
  logic       last_step;

  aes_byte_t  lane_res [LANES];
  logic [3:0] lane_k   [LANES];

  // Lanes cover consecutive bytes idx..idx+LANES-1; because LANES divides 4,
  // all lanes of one step fall within the same column.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0] col_base;
    assign lane_k[l] = idx_q + 4'(l);
    assign col_base  = {lane_k[l][3:2], 2'b00};

    inv_mix_byte u_byte (
      .row    (lane_k[l][1:0]),
      .b0     (state_byte(src_q, col_base)),
      .b1     (state_byte(src_q, col_base + 4'd1)),
      .b2     (state_byte(src_q, col_base + 4'd2)),
      .b3     (state_byte(src_q, col_base + 4'd3)),
      .result (lane_res[l])
    );
  end

  assign last_step = (idx_q == 4'(16 - LANES));

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_CALC;
      ST_CALC: if (last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign state_out = res_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      // NOTE: the data registers are plain flops, not a RAM, so clearing them
      // on reset is cheap and keeps state_out deterministic after reset.
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            src_q <= state_in;
            idx_q <= '0;
          end
        end
        ST_CALC: begin
          for (int l = 0; l < LANES; l++) begin
            res_q[127 - 8*lane_k[l] -: 8] <= lane_res[l];
          end
          idx_q <= idx_q + 4'(LANES);  // wraps to 0 after byte 15
        end
        default: ;
      endcase
    end
  end

endmodule
